// File: rtl/mem_resp.sv
// mem_resp: halfword memory responder for the CPU memory controller.
// MEM_DEPTH x 16-bit array, 1-cycle registered reads, byte-lane writes,
// and a valid/ready byte-stream loader for program images.
// Optional feature macro: MEM_CLEAR_EN. When defined, the array is
// zero-filled one halfword per cycle after reset (CLEAR state). When
// undefined, reset goes straight to IDLE and array contents are undefined.
module mem_resp #(
  parameter  int MEM_DEPTH  = 2**12,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_rd_en,
  input  logic [1:0]            i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [15:0]           i_data,
  output logic [15:0]           o_data,
  output logic                  o_err,
  input  logic                  i_ld_start,
  input  logic                  i_ld_valid,
  input  logic [7:0]            i_ld_byte,
  output logic                  o_ld_ready,
  input  logic                  i_ld_done,
  output logic                  o_busy,
  output logic                  o_ld_ovf
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LD_PTR_LAST = ADDR_WIDTH'(MEM_DEPTH*2 - 1);

  typedef enum logic [1:0] {
`ifdef MEM_CLEAR_EN
    ST_CLEAR,
`endif
    ST_IDLE,
    ST_LOAD
  } state_t;

`ifdef MEM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  localparam logic   RESET_BUSY  = 1'b1;
`else
  localparam state_t RESET_STATE = ST_IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
`endif

  logic [15:0] mem [MEM_DEPTH];

  state_t                state_q, state_d;
  logic [15:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic                  ld_ready_q;
  logic                  busy_q;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] ld_ptr_q, ld_ptr_d;
  logic [7:0]            ld_hold_q, ld_hold_d;
`ifdef MEM_CLEAR_EN
  logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
`endif

  // single array write port shared by clear, CPU and loader
  logic [1:0]       mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [15:0]      mem_wdata;

  logic [IDX_W-1:0] cpu_idx;
  logic             cpu_oor;
  logic             cpu_access;
  logic             unused_addr_lsb;

  assign cpu_idx         = i_addr[ADDR_WIDTH-1:1];
  assign cpu_oor         = (32'(cpu_idx) >= MEM_DEPTH);
  assign cpu_access      = i_en && (i_rd_en || (i_wr_en != 2'b00));
  assign unused_addr_lsb = i_addr[0];

  // next-state, datapath and array write-port selection
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    err_d     = 1'b0;
    ovf_d     = ovf_q;
    ld_ptr_d  = ld_ptr_q;
    ld_hold_d = ld_hold_q;
`ifdef MEM_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    mem_we    = 2'b00;
    mem_widx  = '0;
    mem_wdata = '0;

    case (state_q)
`ifdef MEM_CLEAR_EN
      ST_CLEAR: begin
        mem_we   = 2'b11;
        mem_widx = clr_cnt_q;
        if (clr_cnt_q == IDX_W'(MEM_DEPTH - 1)) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
`endif
      ST_IDLE: begin
        if (cpu_access) begin
          if (cpu_oor) begin
            // nonexistent halfword: drop the write, return zero, flag it
            data_d = 16'h0000;
            err_d  = 1'b1;
          end else begin
            // read-first: data_d sees the array before this edge's write
            if (i_rd_en) begin
              data_d = mem[cpu_idx];
            end
            if (i_wr_en != 2'b00) begin
              mem_we    = i_wr_en;
              mem_widx  = cpu_idx;
              mem_wdata = i_data;
            end
          end
        end
        if (i_ld_start) begin
          state_d  = ST_LOAD;
          ld_ptr_d = '0;
          ovf_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (i_ld_valid && ld_ready_q) begin
          if (!ld_ptr_q[0]) begin
            ld_hold_d = i_ld_byte;
          end else begin
            mem_we    = 2'b11;
            mem_widx  = ld_ptr_q[ADDR_WIDTH-1:1];
            mem_wdata = {i_ld_byte, ld_hold_q};
          end
          if (ld_ptr_q == LD_PTR_LAST) begin
            ld_ptr_d = '0;
            ovf_d    = 1'b1;
          end else begin
            ld_ptr_d = ld_ptr_q + 1'b1;
          end
        end
        if (i_ld_done) begin
          // an odd pointer after this cycle's byte means a lone even byte is held
          if (ld_ptr_d[0]) begin
            mem_we    = 2'b11;
            mem_widx  = ld_ptr_d[ADDR_WIDTH-1:1];
            mem_wdata = {8'h00, ld_hold_d};
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // control state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      data_q     <= 16'h0000;
      err_q      <= 1'b0;
      ld_ready_q <= 1'b0;
      busy_q     <= RESET_BUSY;
      ovf_q      <= 1'b0;
      ld_ptr_q   <= '0;
      ld_hold_q  <= 8'h00;
`ifdef MEM_CLEAR_EN
      clr_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      err_q      <= err_d;
      ld_ready_q <= (state_d == ST_LOAD);
      busy_q     <= (state_d != ST_IDLE);
      ovf_q      <= ovf_d;
      ld_ptr_q   <= ld_ptr_d;
      ld_hold_q  <= ld_hold_d;
`ifdef MEM_CLEAR_EN
      clr_cnt_q  <= clr_cnt_d;
`endif
    end
  end

  // array storage, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (mem_we[0]) begin
      mem[mem_widx][7:0] <= mem_wdata[7:0];
    end
    if (mem_we[1]) begin
      mem[mem_widx][15:8] <= mem_wdata[15:8];
    end
  end

  assign o_data     = data_q;
  assign o_err      = err_q;
  assign o_ld_ready = ld_ready_q;
  assign o_busy     = busy_q;
  assign o_ld_ovf   = ovf_q;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed-vector bench for mem_resp.
// Instance A uses the default depth (4096); instance B uses depth 3000
// so out-of-range halfword indices exist.
module tb_mem_resp;

`ifdef MEM_CLEAR_EN
  localparam int          CLR_A    = 4096;
  localparam logic        BUSY_RST = 1'b1;
  localparam logic [15:0] RST_IDX0 = 16'h0000;
`else
  localparam int          CLR_A    = 0;
  localparam logic        BUSY_RST = 1'b0;
  localparam logic [15:0] RST_IDX0 = 16'h3CC3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A
  logic        a_en = 0, a_rd = 0;
  logic [1:0]  a_wr = 0;
  logic [12:0] a_addr = 0;
  logic [15:0] a_wdata = 0;
  logic [15:0] a_data;
  logic        a_err, a_ready, a_busy, a_ovf;
  logic        a_start = 0, a_valid = 0, a_done = 0;
  logic [7:0]  a_byte = 0;

  // instance B
  logic        b_en = 0, b_rd = 0;
  logic [1:0]  b_wr = 0;
  logic [12:0] b_addr = 0;
  logic [15:0] b_wdata = 0;
  logic [15:0] b_data;
  logic        b_err, b_ready, b_busy, b_ovf;
  logic        b_zero = 0;
  logic [7:0]  b_zbyte = 0;

  mem_resp u_a (
    .clk(clk), .rst(rst), .i_en(a_en), .i_rd_en(a_rd), .i_wr_en(a_wr),
    .i_addr(a_addr), .i_data(a_wdata), .o_data(a_data), .o_err(a_err),
    .i_ld_start(a_start), .i_ld_valid(a_valid), .i_ld_byte(a_byte),
    .o_ld_ready(a_ready), .i_ld_done(a_done), .o_busy(a_busy), .o_ld_ovf(a_ovf)
  );

  mem_resp #(.MEM_DEPTH(3000)) u_b (
    .clk(clk), .rst(rst), .i_en(b_en), .i_rd_en(b_rd), .i_wr_en(b_wr),
    .i_addr(b_addr), .i_data(b_wdata), .o_data(b_data), .o_err(b_err),
    .i_ld_start(b_zero), .i_ld_valid(b_zero), .i_ld_byte(b_zbyte),
    .o_ld_ready(b_ready), .i_ld_done(b_zero), .o_busy(b_busy), .o_ld_ovf(b_ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // all stimulus changes happen 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_read(input logic [12:0] addr);
    a_en = 1; a_rd = 1; a_wr = 0; a_addr = addr;
    tick();
    a_en = 0; a_rd = 0;
  endtask

  task automatic a_write(input logic [12:0] addr, input logic [15:0] d, input logic [1:0] we);
    a_en = 1; a_rd = 0; a_wr = we; a_addr = addr; a_wdata = d;
    tick();
    a_en = 0; a_wr = 0;
  endtask

  task automatic b_read(input logic [12:0] addr);
    b_en = 1; b_rd = 1; b_wr = 0; b_addr = addr;
    tick();
    b_en = 0; b_rd = 0;
  endtask

  task automatic b_write(input logic [12:0] addr, input logic [15:0] d);
    b_en = 1; b_rd = 0; b_wr = 2'b11; b_addr = addr; b_wdata = d;
    tick();
    b_en = 0; b_wr = 0;
  endtask

  task automatic ld_byte(input logic [7:0] b);
    a_valid = 1; a_byte = b;
    tick();
    a_valid = 0;
  endtask

  task automatic ld_start();
    a_start = 1;
    tick();
    a_start = 0;
  endtask

  task automatic ld_done();
    a_done = 1;
    tick();
    a_done = 0;
  endtask

  initial begin
    int n;
    logic [7:0] bv;

    // ---------------- reset values
    tick(); tick();
    check("rst_data",  32'(a_data),  32'h0);
    check("rst_err",   32'(a_err),   32'h0);
    check("rst_ready", 32'(a_ready), 32'h0);
    check("rst_busy",  32'(a_busy),  32'(BUSY_RST));
    check("rst_ovf",   32'(a_ovf),   32'h0);
    rst = 0;

    // ---------------- clear duration
    n = 0;
    while (a_busy && n < 10000) begin
      tick();
      n++;
    end
    check("clr_cycles", 32'(n), 32'(CLR_A));
    check("b_busy_done", 32'(b_busy), 32'h0);

`ifdef MEM_CLEAR_EN
    a_read(13'h0000);
    check("clr_idx0", 32'(a_data), 32'h0000);
    a_write(13'h0000, 16'hBEEF, 2'b11);
    a_read(13'h0000);
    a_read(13'h1FFE);
    check("clr_idx_last", 32'(a_data), 32'h0000);
`endif

    // ---------------- byte-lane writes
    a_write(13'h0010, 16'hA55A, 2'b11);
    a_write(13'h0010, 16'h00FF, 2'b01);
    a_read(13'h0011);
    check("lane_write", 32'(a_data), 32'hA5FF);
    a_write(13'h0010, 16'h3C00, 2'b10);
    a_read(13'h0010);
    check("lane_hi", 32'(a_data), 32'h3CFF);
    a_write(13'h0010, 16'hA5FF, 2'b11);

    // ---------------- same-cycle read+write is read-first
    a_write(13'h0020, 16'h1234, 2'b11);
    a_en = 1; a_rd = 1; a_wr = 2'b11; a_addr = 13'h0020; a_wdata = 16'h5678;
    tick();
    a_en = 0; a_rd = 0; a_wr = 0;
    check("rw_old", 32'(a_data), 32'h1234);
    tick();
    check("data_hold", 32'(a_data), 32'h1234);
    a_read(13'h0020);
    check("rw_new", 32'(a_data), 32'h5678);

    // ---------------- odd-length load; start cycle still serves a CPU read
    a_en = 1; a_rd = 1; a_addr = 13'h0010; a_start = 1;
    tick();
    a_en = 0; a_rd = 0; a_start = 0;
    check("start_cpu_rd", 32'(a_data), 32'hA5FF);
    check("ld_ready", 32'(a_ready), 32'h1);
    check("ld_busy",  32'(a_busy),  32'h1);
    ld_byte(8'h11);
    ld_byte(8'h22);
    // idle cycle: a second start must not rewind, and CPU reads are blocked
    a_start = 1; a_en = 1; a_rd = 1; a_addr = 13'h0020;
    tick();
    a_start = 0; a_en = 0; a_rd = 0;
    check("ld_cpu_blocked", 32'(a_data), 32'hA5FF);
    ld_byte(8'h33);
    ld_done();
    check("done_ready", 32'(a_ready), 32'h0);
    check("done_busy",  32'(a_busy),  32'h0);
    check("done_ovf",   32'(a_ovf),   32'h0);
    a_read(13'h0000);
    check("ld_idx0", 32'(a_data), 32'h2211);
    a_read(13'h0002);
    check("ld_idx1", 32'(a_data), 32'h0033);

    // ---------------- done together with valid
    ld_start();
    a_valid = 1; a_byte = 8'h44; a_done = 1;
    tick();
    a_valid = 0; a_done = 0;
    a_read(13'h0000);
    check("done_even", 32'(a_data), 32'h0044);
    ld_start();
    ld_byte(8'h55);
    a_valid = 1; a_byte = 8'h66; a_done = 1;
    tick();
    a_valid = 0; a_done = 0;
    a_read(13'h0000);
    check("done_odd", 32'(a_data), 32'h6655);
    a_read(13'h0002);
    check("done_odd_idx1", 32'(a_data), 32'h0033);

    // ---------------- out-of-range on the 3000-deep instance
    b_write(13'd5998, 16'h1357);
    b_write(13'd0,    16'h2468);
    b_read(13'd5998);
    check("b_last", 32'(b_data), 32'h1357);
    b_read(13'd6000);
    check("b_oor_err",  32'(b_err),  32'h1);
    check("b_oor_data", 32'(b_data), 32'h0000);
    tick();
    check("b_err_pulse", 32'(b_err), 32'h0);
    b_write(13'd6000, 16'hFFFF);
    check("b_oor_werr", 32'(b_err), 32'h1);
    b_read(13'd5998);
    check("b_keep_last", 32'(b_data), 32'h1357);
    check("b_err_clear", 32'(b_err),  32'h0);
    b_read(13'd0);
    check("b_keep_idx0", 32'(b_data), 32'h2468);

    // ---------------- pointer wrap: 8194 bytes
    ld_start();
    for (int i = 0; i < 8194; i++) begin
      if (i == 8192)      bv = 8'hC3;
      else if (i == 8193) bv = 8'h3C;
      else                bv = i[7:0];
      ld_byte(bv);
      if (i == 8190) check("ovf_before_wrap", 32'(a_ovf), 32'h0);
      if (i == 8191) check("ovf_at_wrap",     32'(a_ovf), 32'h1);
    end
    ld_done();
    check("ovf_sticky", 32'(a_ovf), 32'h1);
    a_read(13'h0000);
    check("wrap_idx0", 32'(a_data), 32'h3CC3);
    a_read(13'h0002);
    check("wrap_idx1", 32'(a_data), 32'h0302);
    a_read(13'h1FFE);
    check("wrap_last", 32'(a_data), 32'hFFFE);
    ld_start();
    check("start_clr_ovf", 32'(a_ovf), 32'h0);
    ld_done();

    // ---------------- asynchronous reset mid-load
    ld_start();
    ld_byte(8'h77);
    #2 rst = 1;
    #1;
    check("arst_ready", 32'(a_ready), 32'h0);
    check("arst_busy",  32'(a_busy),  32'(BUSY_RST));
    tick();
    rst = 0;
    n = 0;
`ifdef MEM_CLEAR_EN
    a_start = 1;
    tick();
    a_start = 0;
    n++;
    check("start_in_clear", 32'(a_ready), 32'h0);
`endif
    while (a_busy && n < 10000) begin
      tick();
      n++;
    end
    check("clr_restart", 32'(n), 32'(CLR_A));
    a_read(13'h0000);
    check("rst_load_lost", 32'(a_data), 32'(RST_IDX0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
